// File: rtl/mpu_bus_master_if.sv
// Host request/response handshake plus ChronoCube MPU strobe bus, bundled for mpu_bus_master.
// Burst-only signals exist when MPU_MASTER_BURST_EN is defined.
interface mpu_bus_master_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [1:0]            req_be;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  busy;
  logic                  _mpu_en;
  logic                  _mpu_rd;
  logic                  _mpu_wr;
  logic [1:0]            _mpu_be;
  logic [ADDR_WIDTH-1:0] mpu_addr;
  logic [DATA_WIDTH-1:0] mpu_wdata;
  logic [DATA_WIDTH-1:0] mpu_rdata;
`ifdef MPU_MASTER_BURST_EN
  logic [7:0]            req_len;
  logic                  rsp_last;
`endif

  modport master (
`ifdef MPU_MASTER_BURST_EN
    input  req_len,
    output rsp_last,
`endif
    input  req_valid, req_wr, req_addr, req_wdata, req_be, mpu_rdata,
    output req_ready, rsp_valid, rsp_rdata, busy,
    output _mpu_en, _mpu_rd, _mpu_wr, _mpu_be, mpu_addr, mpu_wdata
  );

  modport slave (
`ifdef MPU_MASTER_BURST_EN
    output req_len,
    input  rsp_last,
`endif
    output req_valid, req_wr, req_addr, req_wdata, req_be, mpu_rdata,
    input  req_ready, rsp_valid, rsp_rdata, busy,
    input  _mpu_en, _mpu_rd, _mpu_wr, _mpu_be, mpu_addr, mpu_wdata
  );
endinterface

// File: rtl/mpu_bus_master.sv
// ChronoCube MPU-side bus initiator: turns single-word host requests into timed active-low strobe cycles.
// Optional MPU_MASTER_BURST_EN adds req_len/rsp_last and incrementing-address bursts.
module mpu_bus_master #(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned SETUP_CYCLES  = 1,
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES   = 1
) (
  input  logic             clk,
  input  logic             _reset,
  mpu_bus_master_if.master bus
);

  localparam int unsigned MAX_PHASE =
    (SETUP_CYCLES > STROBE_CYCLES)
      ? ((SETUP_CYCLES  > HOLD_CYCLES) ? SETUP_CYCLES  : HOLD_CYCLES)
      : ((STROBE_CYCLES > HOLD_CYCLES) ? STROBE_CYCLES : HOLD_CYCLES);
  localparam int unsigned CNT_W = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
  } state_e;

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  wr_q;
  logic                  req_ready_q;
  logic                  busy_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  en_n_q;
  logic                  rd_n_q;
  logic                  wr_n_q;
  logic [1:0]            be_n_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
`ifdef MPU_MASTER_BURST_EN
  logic [7:0]            left_q;
  logic [1:0]            burst_be_n_q;
  logic                  rsp_last_q;
`endif

  // Phase sequencer: every phase loads cnt_q with its length-1 and advances when it reaches zero.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      en_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      be_n_q       <= 2'b11;
      addr_q       <= '0;
      wdata_q      <= '0;
`ifdef MPU_MASTER_BURST_EN
      left_q       <= '0;
      burst_be_n_q <= 2'b11;
      rsp_last_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            state_q     <= S_SETUP;
            cnt_q       <= SETUP_LD;
            wr_q        <= bus.req_wr;
            addr_q      <= bus.req_addr;
            be_n_q      <= ~bus.req_be;
            en_n_q      <= 1'b0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (bus.req_wr) begin
              wdata_q <= bus.req_wdata;
            end
`ifdef MPU_MASTER_BURST_EN
            left_q       <= bus.req_len;
            burst_be_n_q <= ~bus.req_be;
`endif
          end
        end

        S_SETUP: begin
          if (cnt_q == '0) begin
            state_q <= S_STROBE;
            cnt_q   <= STROBE_LD;
            if (wr_q) begin
              wr_n_q <= 1'b0;
            end else begin
              rd_n_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        // Last strobe edge: the synchronous RAM output has had a full cycle to settle.
        S_STROBE: begin
          if (cnt_q == '0) begin
            state_q     <= S_HOLD;
            cnt_q       <= HOLD_LD;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rsp_rdata_q <= wr_q ? '0 : bus.mpu_rdata;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        S_HOLD: begin
          if (cnt_q == '0) begin
            state_q     <= S_RESP;
            en_n_q      <= 1'b1;
            be_n_q      <= 2'b11;
            rsp_valid_q <= 1'b1;
`ifdef MPU_MASTER_BURST_EN
            rsp_last_q  <= (left_q == '0);
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        S_RESP: begin
`ifdef MPU_MASTER_BURST_EN
          rsp_last_q <= 1'b0;
          // Address only moves here, while _mpu_en is high between words.
          if (left_q != '0) begin
            state_q <= S_SETUP;
            cnt_q   <= SETUP_LD;
            left_q  <= left_q - 8'(1);
            addr_q  <= addr_q + ADDR_WIDTH'(1);
            be_n_q  <= burst_be_n_q;
            en_n_q  <= 1'b0;
          end else begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
`else
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
`endif
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus._mpu_en   = en_n_q;
  assign bus._mpu_rd   = rd_n_q;
  assign bus._mpu_wr   = wr_n_q;
  assign bus._mpu_be   = be_n_q;
  assign bus.mpu_addr  = addr_q;
  assign bus.mpu_wdata = wdata_q;
`ifdef MPU_MASTER_BURST_EN
  assign bus.rsp_last  = rsp_last_q;
`endif

endmodule

// File: tb/tb_mpu_bus_master.sv
// Self-checking bench for mpu_bus_master: directed vector table, randomized traffic against a
// request-level memory model, plus back-to-back, async-reset and (MPU_MASTER_BURST_EN) burst sequences.
module tb_mpu_bus_master;

  localparam int unsigned SETUP  = 1;
  localparam int unsigned STROBE = 2;
  localparam int unsigned HOLD   = 1;
  localparam int unsigned EXP_LAT = SETUP + STROBE + HOLD + 1;

  logic clk;
  logic _reset;
  int   total;
  int   bad;

  mpu_bus_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

  mpu_bus_master #(
    .ADDR_WIDTH(16), .DATA_WIDTH(16),
    .SETUP_CYCLES(SETUP), .STROBE_CYCLES(STROBE), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    ._reset(_reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content never written reads back as a fixed scramble of the address.
  function automatic logic [15:0] dflt(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  logic [15:0] smem    [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];

  function automatic logic [15:0] s_read(input logic [15:0] a);
    return smem.exists(a) ? smem[a] : dflt(a);
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = nw[7:0];
    if (be[1]) r[15:8] = nw[15:8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus slave: synchronous RAM, read data appears one cycle after the read strobe falls.
  always @(posedge clk) begin
    if (_reset && !bus._mpu_en && !bus._mpu_wr)
      smem[bus.mpu_addr] = merge(s_read(bus.mpu_addr), bus.mpu_wdata, ~bus._mpu_be);
    bus.mpu_rdata <= (!bus._mpu_en && !bus._mpu_rd) ? s_read(bus.mpu_addr) : 16'hDEAD;
  end

  // Bus-level invariants sampled mid-cycle.
  logic        prev_en_low;
  logic [15:0] prev_addr;
  always @(negedge clk) begin
    if (_reset) begin
      chk("rd_wr_exclusive", 32'(bus._mpu_rd | bus._mpu_wr), 32'd1);
      chk("strobe_needs_en", 32'((!bus._mpu_rd || !bus._mpu_wr) && bus._mpu_en), 32'd0);
      chk("busy_eq_not_ready", 32'(bus.busy ^ bus.req_ready), 32'd1);
      if (prev_en_low && !bus._mpu_en)
        chk("addr_stable_en_low", 32'(bus.mpu_addr), 32'(prev_addr));
    end
    prev_en_low = _reset && !bus._mpu_en;
    prev_addr   = bus.mpu_addr;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          lat;
    int          en_low;
    int          rd_low;
    int          wr_low;
    logic [1:0]  be_seen;
    logic        be_stable;
    logic        addr_ok;
    logic        ready_ok;
    logic [15:0] rdata;
    logic [15:0] wdata_seen;
  } obs_t;

  // Issue one request and observe the bus until the response pulse (or a cycle budget runs out).
  task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [1:0] be, output obs_t o);
    int guard;
    o = '{default: 0};
    o.be_stable = 1'b1;
    o.addr_ok   = 1'b1;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
`ifdef MPU_MASTER_BURST_EN
    bus.req_len   = 8'd0;
`endif
    bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("accept_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'($urandom);
    bus.req_addr  = 16'($urandom);
    bus.req_wdata = 16'($urandom);
    bus.req_be    = 2'($urandom);
    for (int c = 1; c <= 30; c++) begin
      if (!bus._mpu_en) begin
        if (o.en_low == 0) begin
          o.be_seen    = bus._mpu_be;
          o.wdata_seen = bus.mpu_wdata;
        end else if (bus._mpu_be != o.be_seen) begin
          o.be_stable = 1'b0;
        end
        if (bus.mpu_addr != addr) o.addr_ok = 1'b0;
        o.en_low++;
      end
      if (!bus._mpu_rd) o.rd_low++;
      if (!bus._mpu_wr) o.wr_low++;
      if (bus.rsp_valid) begin
        o.lat      = c;
        o.rdata    = bus.rsp_rdata;
        o.ready_ok = !bus.req_ready && bus.busy;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic check_txn(input string tag, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [1:0] be,
                           input logic [15:0] exp_rdata, input logic [1:0] exp_be_n);
    obs_t o;
    run_txn(wr, addr, wdata, be, o);
    chk({tag, "_latency"}, 32'(o.lat), 32'(EXP_LAT));
    chk({tag, "_en_low_cycles"}, 32'(o.en_low), 32'(SETUP + STROBE + HOLD));
    chk({tag, "_rd_low_cycles"}, 32'(o.rd_low), wr ? 32'd0 : 32'(STROBE));
    chk({tag, "_wr_low_cycles"}, 32'(o.wr_low), wr ? 32'(STROBE) : 32'd0);
    chk({tag, "_be_n"}, 32'({o.be_stable, o.be_seen}), 32'({1'b1, exp_be_n}));
    chk({tag, "_addr"}, 32'(o.addr_ok), 32'd1);
    chk({tag, "_resp_ready_low"}, 32'(o.ready_ok), 32'd1);
    chk({tag, "_rdata"}, 32'(o.rdata), 32'(exp_rdata));
    if (wr) begin
      chk({tag, "_wdata"}, 32'(o.wdata_seen), 32'(wdata));
      ref_mem[addr] = merge(ref_read(addr), wdata, be);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rdata;
    logic [1:0]  exp_be_n;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [15:0] ctrl;
    int guard;
    int pulses;

    total = 0;
    bad   = 0;
    prev_en_low = 1'b0;
    prev_addr   = '0;
    vecs[0] = '{1'b1, 16'h0104, 16'hBEEF, 2'b01, 16'h0000, 2'b10};
    vecs[1] = '{1'b0, 16'h2000, 16'h5555, 2'b11, 16'h1234, 2'b00};
    vecs[2] = '{1'b1, 16'h0200, 16'hCAFE, 2'b11, 16'h0000, 2'b00};
    vecs[3] = '{1'b0, 16'h0200, 16'h5555, 2'b11, 16'hCAFE, 2'b00};
    vecs[4] = '{1'b1, 16'h0200, 16'h1100, 2'b10, 16'h0000, 2'b01};
    vecs[5] = '{1'b0, 16'h0200, 16'h5555, 2'b01, 16'h11FE, 2'b10};
    vecs[6] = '{1'b0, 16'h0104, 16'h5555, 2'b11, 16'hA4EF, 2'b00};
    smem[16'h2000]    = 16'h1234;
    ref_mem[16'h2000] = 16'h1234;

    _reset        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = 2'b00;
`ifdef MPU_MASTER_BURST_EN
    bus.req_len   = 8'd0;
`endif
    repeat (3) tick();
    #2 _reset = 1'b1;

    // Idle after reset: {en, rd, wr, be[1:0], ready, rsp_valid, busy} = 8'hFC.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ctrl", 32'({bus._mpu_en, bus._mpu_rd, bus._mpu_wr, bus._mpu_be,
                            bus.req_ready, bus.rsp_valid, bus.busy}), 32'hFC);
    end
    chk("idle_addr_wdata_rdata", 32'({bus.mpu_addr, bus.mpu_wdata} | 32'(bus.rsp_rdata)), 32'd0);

    for (int i = 0; i < 7; i++)
      check_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].be, vecs[i].exp_rdata, vecs[i].exp_be_n);

    // Randomized traffic on a small address window so reads hit earlier writes.
    for (int i = 0; i < 40; i++) begin
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [1:0]  be;
      wr    = 1'($urandom_range(0, 1));
      addr  = 16'h0100 + 16'($urandom_range(0, 7));
      wdata = 16'($urandom);
      be    = 2'($urandom_range(0, 3));
      check_txn($sformatf("rnd%0d", i), wr, addr, wdata, be, wr ? 16'h0000 : ref_read(addr), ~be);
      repeat ($urandom_range(0, 2)) tick();
    end

    // Back-to-back: req_valid held high across two requests.
    bus.req_wr = 1'b1; bus.req_addr = 16'h0300; bus.req_wdata = 16'h0F0F; bus.req_be = 2'b11;
    bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin tick(); guard++; end
    tick();
    guard = 0;
    while (!bus.rsp_valid && guard < 30) begin tick(); guard++; end
    chk("b2b_first_rsp", 32'(bus.rsp_valid), 32'd1);
    chk("b2b_ready_in_resp", 32'(bus.req_ready), 32'd0);
    ref_mem[16'h0300] = merge(ref_read(16'h0300), 16'h0F0F, 2'b11);
    bus.req_wr = 1'b0;
    tick();
    chk("b2b_gap_cycle", 32'({bus.req_ready, bus._mpu_en, bus.rsp_valid}), 32'b110);
    tick();
    chk("b2b_second_accepted", 32'({bus._mpu_en, bus.req_ready, bus.mpu_addr}), 32'({2'b00, 16'h0300}));
    bus.req_valid = 1'b0;
    guard = 0;
    while (!bus.rsp_valid && guard < 30) begin tick(); guard++; end
    chk("b2b_second_rdata", 32'(bus.rsp_rdata), 32'(ref_read(16'h0300)));
    tick();

    // Reset asserted mid-strobe of a write: outputs must return without a clock edge.
    bus.req_wr = 1'b1; bus.req_addr = 16'h7777; bus.req_wdata = 16'h1357; bus.req_be = 2'b11;
    bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin tick(); guard++; end
    tick();
    bus.req_valid = 1'b0;
    guard = 0;
    while (bus._mpu_wr && guard < 10) begin tick(); guard++; end
    chk("rst_strobe_reached", 32'(bus._mpu_wr), 32'd0);
    #2 _reset = 1'b0;
    #1;
    ctrl = 16'({bus._mpu_en, bus._mpu_rd, bus._mpu_wr, bus._mpu_be, bus.req_ready, bus.rsp_valid, bus.busy});
    chk("rst_async_ctrl", 32'(ctrl), 32'hFC);
    chk("rst_async_addr_wdata", 32'({bus.mpu_addr, bus.mpu_wdata}), 32'd0);
    @(posedge clk);
    #3 _reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rsp_valid) pulses++;
    end
    chk("rst_no_rsp", 32'(pulses), 32'd0);
    check_txn("post_rst", 1'b0, 16'h2000, 16'h0000, 2'b11, 16'h1234, 2'b00);

`ifdef MPU_MASTER_BURST_EN
    begin
      logic [15:0] seen_addr[$];
      logic [2:0]  last_pat;
      logic        prev_rd;
      bus.req_wr = 1'b0; bus.req_addr = 16'hFFFE; bus.req_be = 2'b11; bus.req_len = 8'd2;
      bus.req_valid = 1'b1;
      guard = 0;
      while (!bus.req_ready && guard < 50) begin tick(); guard++; end
      tick();
      bus.req_valid = 1'b0;
      bus.req_len   = 8'd0;
      pulses   = 0;
      last_pat = 3'b000;
      prev_rd  = 1'b1;
      for (int c = 0; c < 60 && pulses < 3; c++) begin
        if (prev_rd && !bus._mpu_rd) seen_addr.push_back(bus.mpu_addr);
        prev_rd = bus._mpu_rd;
        if (bus.rsp_valid) begin
          chk($sformatf("burst_rdata%0d", pulses), 32'(bus.rsp_rdata),
              32'(ref_read(16'hFFFE + 16'(pulses))));
          chk($sformatf("burst_ready_low%0d", pulses), 32'(bus.req_ready), 32'd0);
          last_pat[pulses] = bus.rsp_last;
          pulses++;
        end
        if (pulses < 3) tick();
      end
      chk("burst_pulses", 32'(pulses), 32'd3);
      chk("burst_last_pattern", 32'(last_pat), 32'b100);
      chk("burst_addr_count", 32'(seen_addr.size()), 32'd3);
      if (seen_addr.size() == 3)
        chk("burst_addrs", 32'({seen_addr[0], seen_addr[1]} ^ 32'(seen_addr[2])), 32'hFFFEFFFF);
      tick();
      chk("burst_ready_after", 32'({bus.req_ready, bus.rsp_last}), 32'b10);
    end
`endif

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
